// File: rtl/out_reg_bank_if.sv
// Fabric-to-pad output register bank bus.
// Groups the data, mode and HOLD handshake signals.
interface out_reg_bank_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] OQI;
    logic             OQI_VLD;
    logic [1:0]       OSEL;
    logic             OEN;
    logic             CAP_STB;
    logic             F2A_ACK;
    logic             OVR_CLR;
    logic [WIDTH-1:0] F2A;
    logic             F2A_VLD;
    logic             OVR;

    modport master (
        output OQI, OQI_VLD, OSEL, OEN,
        output CAP_STB, F2A_ACK, OVR_CLR,
        input  F2A, F2A_VLD, OVR
    );

    modport slave (
        input  OQI, OQI_VLD, OSEL, OEN,
        input  CAP_STB, F2A_ACK, OVR_CLR,
        output F2A, F2A_VLD, OVR
    );
endinterface

// File: rtl/out_reg_bank.sv
// WIDTH-bit output register bank: bypass, single reg,
// DEPTH-stage pipe and strobe-captured hold with overrun.
module out_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic           IQC,
    input logic           QRT,
    out_reg_bank_if.slave bus
);
    localparam logic [1:0] M_BYP  = 2'd0;
    localparam logic [1:0] M_REG  = 2'd1;
    localparam logic [1:0] M_PIPE = 2'd2;
    localparam logic [1:0] M_HOLD = 2'd3;

    typedef enum logic {
        H_EMPTY = 1'b0,
        H_FULL  = 1'b1
    } hstate_e;

    logic [WIDTH-1:0] sdat_q [DEPTH];
    logic [DEPTH-1:0] svld_q;

    hstate_e          hst_q, hst_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             ovr_q, ovr_d;
    logic             cap;
    logic             ovr_set;

    // Pipeline shifts on every enabled edge, whatever the mode.
    always_ff @(posedge IQC or negedge QRT) begin
        if (!QRT) begin
            for (int i = 0; i < DEPTH; i++) begin
                sdat_q[i] <= RESET_VAL;
            end
            svld_q <= '0;
        end else if (bus.OEN) begin
            sdat_q[0] <= bus.OQI;
            for (int i = 1; i < DEPTH; i++) begin
                sdat_q[i] <= sdat_q[i-1];
            end
            svld_q <= {svld_q[DEPTH-2:0], bus.OQI_VLD};
        end
    end

    // Hold register, hold state and sticky overrun flag.
    always_ff @(posedge IQC or negedge QRT) begin
        if (!QRT) begin
            hst_q  <= H_EMPTY;
            hold_q <= RESET_VAL;
            ovr_q  <= 1'b0;
        end else begin
            hst_q  <= hst_d;
            hold_q <= hold_d;
            ovr_q  <= ovr_d;
        end
    end

    assign cap = bus.CAP_STB & bus.OQI_VLD;

    // HOLD next state; only advances while HOLD is selected.
    // A new overrun beats a same-edge clear.
    always_comb begin
        hst_d   = hst_q;
        hold_d  = hold_q;
        ovr_set = 1'b0;
        ovr_d   = ovr_q;
        if (bus.OSEL == M_HOLD) begin
            unique case (hst_q)
                H_EMPTY: begin
                    if (cap) begin
                        hold_d = bus.OQI;
                        hst_d  = H_FULL;
                    end
                end
                H_FULL: begin
                    if (cap) begin
                        hold_d  = bus.OQI;
                        ovr_set = ~bus.F2A_ACK;
                    end else if (bus.F2A_ACK) begin
                        hst_d = H_EMPTY;
                    end
                end
                default: hst_d = H_EMPTY;
            endcase
        end
        if (bus.OVR_CLR) begin
            ovr_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end
    end

    // Output tap follows OSEL immediately; no flush on a switch.
    always_comb begin
        bus.F2A     = bus.OQI;
        bus.F2A_VLD = bus.OQI_VLD;
        unique case (bus.OSEL)
            M_BYP: begin
                bus.F2A     = bus.OQI;
                bus.F2A_VLD = bus.OQI_VLD;
            end
            M_REG: begin
                bus.F2A     = sdat_q[0];
                bus.F2A_VLD = svld_q[0];
            end
            M_PIPE: begin
                bus.F2A     = sdat_q[DEPTH-1];
                bus.F2A_VLD = svld_q[DEPTH-1];
            end
            M_HOLD: begin
                bus.F2A     = hold_q;
                bus.F2A_VLD = (hst_q == H_FULL);
            end
            default: begin
                bus.F2A     = bus.OQI;
                bus.F2A_VLD = bus.OQI_VLD;
            end
        endcase
    end

    assign bus.OVR = ovr_q;
endmodule

// File: tb/tb_out_reg_bank.sv
// Self-checking bench for out_reg_bank: directed table,
// reset corner sequences and a randomized model run.
module tb_out_reg_bank;
    localparam int         W  = 8;
    localparam int         D  = 3;
    localparam logic [7:0] RV = 8'h00;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    out_reg_bank_if #(.WIDTH(W)) bus ();

    out_reg_bank #(
        .WIDTH(W),
        .DEPTH(D),
        .RESET_VAL(RV)
    ) dut (
        .IQC(clk),
        .QRT(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] osel;
        logic       oen;
        logic [7:0] oqi;
        logic       vld;
        logic       cap;
        logic       ack;
        logic       clr;
        logic [7:0] e_f2a;
        logic       e_vld;
        logic       e_ovr;
    } vec_t;

    vec_t vt [$];

    // Behavioural model: pipe is a history of presented words.
    logic [7:0] mq_d [$];
    logic       mq_v [$];
    logic [7:0] m_hd;
    logic       m_hv;
    logic       m_ovr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] osel, input logic oen,
                          input logic [7:0] oqi, input logic vld,
                          input logic cap, input logic ack,
                          input logic clr);
        bus.OSEL    = osel;
        bus.OEN     = oen;
        bus.OQI     = oqi;
        bus.OQI_VLD = vld;
        bus.CAP_STB = cap;
        bus.F2A_ACK = ack;
        bus.OVR_CLR = clr;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq_d  = {};
        mq_v  = {};
        for (int i = 0; i < D; i++) begin
            mq_d.push_back(RV);
            mq_v.push_back(1'b0);
        end
        m_hd  = RV;
        m_hv  = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic model_step();
        logic c;
        logic setv;
        setv = 1'b0;
        if (bus.OEN) begin
            mq_d.push_front(bus.OQI);
            mq_v.push_front(bus.OQI_VLD);
            void'(mq_d.pop_back());
            void'(mq_v.pop_back());
        end
        if (bus.OSEL == 2'd3) begin
            c = bus.CAP_STB && bus.OQI_VLD;
            if (!m_hv) begin
                if (c) begin
                    m_hd = bus.OQI;
                    m_hv = 1'b1;
                end
            end else if (c) begin
                m_hd = bus.OQI;
                if (!bus.F2A_ACK) setv = 1'b1;
            end else if (bus.F2A_ACK) begin
                m_hv = 1'b0;
            end
        end
        if (bus.OVR_CLR) m_ovr = 1'b0;
        if (setv) m_ovr = 1'b1;
    endtask

    task automatic model_check(input int n);
        logic [7:0] ef;
        logic       ev;
        case (bus.OSEL)
            2'd0: begin ef = bus.OQI; ev = bus.OQI_VLD; end
            2'd1: begin ef = mq_d[0]; ev = mq_v[0]; end
            2'd2: begin ef = mq_d[D-1]; ev = mq_v[D-1]; end
            default: begin ef = m_hd; ev = m_hv; end
        endcase
        chk($sformatf("rnd%0d_f2a", n), bus.F2A, ef);
        chk($sformatf("rnd%0d_vld", n), bus.F2A_VLD, ev);
        chk($sformatf("rnd%0d_ovr", n), bus.OVR, m_ovr);
    endtask

    function automatic vec_t mk(
        logic [1:0] osel, logic oen, logic [7:0] oqi, logic vld,
        logic cap, logic ack, logic clr,
        logic [7:0] ef, logic ev, logic eo);
        vec_t v;
        v.osel = osel; v.oen = oen; v.oqi = oqi; v.vld = vld;
        v.cap = cap; v.ack = ack; v.clr = clr;
        v.e_f2a = ef; v.e_vld = ev; v.e_ovr = eo;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;

        // REG sequence, then bypass
        vt.push_back(mk(1, 1, 8'h11, 1, 0, 0, 0, 8'h11, 1, 0));
        vt.push_back(mk(1, 1, 8'h22, 1, 0, 0, 0, 8'h22, 1, 0));
        vt.push_back(mk(1, 1, 8'h33, 1, 0, 0, 0, 8'h33, 1, 0));
        vt.push_back(mk(0, 1, 8'h44, 1, 0, 0, 0, 8'h44, 1, 0));
        // PIPE with a 2-cycle enable gap after 0x02
        vt.push_back(mk(2, 1, 8'h01, 1, 0, 0, 0, 8'h33, 1, 0));
        vt.push_back(mk(2, 1, 8'h02, 1, 0, 0, 0, 8'h44, 1, 0));
        vt.push_back(mk(2, 0, 8'h03, 1, 0, 0, 0, 8'h44, 1, 0));
        vt.push_back(mk(2, 0, 8'h03, 1, 0, 0, 0, 8'h44, 1, 0));
        vt.push_back(mk(2, 1, 8'h03, 1, 0, 0, 0, 8'h01, 1, 0));
        vt.push_back(mk(2, 1, 8'h04, 1, 0, 0, 0, 8'h02, 1, 0));
        vt.push_back(mk(2, 1, 8'h00, 0, 0, 0, 0, 8'h03, 1, 0));
        vt.push_back(mk(2, 1, 8'h00, 0, 0, 0, 0, 8'h04, 1, 0));
        vt.push_back(mk(2, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0));
        // HOLD captures, ack, overrun
        vt.push_back(mk(3, 0, 8'h5A, 1, 1, 0, 0, 8'h5A, 1, 0));
        vt.push_back(mk(3, 0, 8'h6B, 1, 1, 1, 0, 8'h6B, 1, 0));
        vt.push_back(mk(3, 0, 8'h7C, 1, 1, 0, 0, 8'h7C, 1, 1));
        vt.push_back(mk(3, 0, 8'h00, 0, 0, 1, 0, 8'h7C, 0, 1));
        vt.push_back(mk(3, 0, 8'hEE, 0, 1, 0, 0, 8'h7C, 0, 1));
        vt.push_back(mk(3, 0, 8'h00, 0, 0, 1, 0, 8'h7C, 0, 1));
        // Overrun set beats clear, then clear alone
        vt.push_back(mk(3, 0, 8'h81, 1, 1, 0, 0, 8'h81, 1, 1));
        vt.push_back(mk(3, 0, 8'h92, 1, 1, 0, 1, 8'h92, 1, 1));
        vt.push_back(mk(3, 0, 8'h92, 0, 0, 0, 1, 8'h92, 1, 0));
        // Hold frozen outside HOLD mode
        vt.push_back(mk(1, 0, 8'hC3, 1, 1, 1, 0, 8'h00, 0, 0));
        vt.push_back(mk(3, 0, 8'hAA, 1, 0, 0, 0, 8'h92, 1, 0));

        // Reset held: registered modes show reset, bypass passes
        rst_n = 1'b0;
        set_in(0, 1, 8'hA5, 1, 1, 0, 0);
        repeat (3) edge1();
        for (int m = 0; m < 4; m++) begin
            bus.OSEL = 2'(m);
            #1;
            chk($sformatf("rst_m%0d_f2a", m), bus.F2A,
                (m == 0) ? 8'hA5 : RV);
            chk($sformatf("rst_m%0d_vld", m), bus.F2A_VLD,
                (m == 0) ? 1'b1 : 1'b0);
            chk($sformatf("rst_m%0d_ovr", m), bus.OVR, 1'b0);
        end
        set_in(0, 0, 8'h00, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        edge1();

        foreach (vt[i]) begin
            set_in(vt[i].osel, vt[i].oen, vt[i].oqi, vt[i].vld,
                   vt[i].cap, vt[i].ack, vt[i].clr);
            edge1();
            chk($sformatf("vec%0d_f2a", i), bus.F2A, vt[i].e_f2a);
            chk($sformatf("vec%0d_vld", i), bus.F2A_VLD, vt[i].e_vld);
            chk($sformatf("vec%0d_ovr", i), bus.OVR, vt[i].e_ovr);
        end

        // Async reset in PIPE with a full pipe, then latency
        for (int i = 0; i < D; i++) begin
            set_in(2, 1, 8'(8'h10 + i), 1, 0, 0, 0);
            edge1();
        end
        chk("full_f2a", bus.F2A, 8'h10);
        chk("full_vld", bus.F2A_VLD, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_f2a", bus.F2A, RV);
        chk("async_vld", bus.F2A_VLD, 1'b0);
        #2;
        rst_n = 1'b1;
        set_in(2, 1, 8'h99, 1, 0, 0, 0);
        edge1();
        set_in(2, 1, 8'h00, 0, 0, 0, 0);
        chk("lat_e1_vld", bus.F2A_VLD, 1'b0);
        edge1();
        chk("lat_e2_vld", bus.F2A_VLD, 1'b0);
        edge1();
        chk("lat_e3_f2a", bus.F2A, 8'h99);
        chk("lat_e3_vld", bus.F2A_VLD, 1'b1);

        // Randomized run against the model
        set_in(0, 0, 8'h00, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int n = 0; n < 600; n++) begin
            set_in(2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) != 0),
                   8'($urandom),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 1) != 0),
                   ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 9) == 0));
            model_step();
            edge1();
            model_check(n);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
